// File: rtl/vram_arbiter_pkg.sv
// vram_arbiter_pkg: shared FSM/slot-owner encodings and default widths for the video RAM arbiter.
package vram_arbiter_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_ACK     = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_WB   = 2'd2,
        OWN_CPU  = 2'd3
    } owner_e;

    // Fixed priority: video, buffer drain, CPU read, idle.
    function automatic owner_e slot_owner(input logic vid, input logic wb, input logic cpu_rd);
        return vid ? OWN_VID : wb ? OWN_WB : cpu_rd ? OWN_CPU : OWN_NONE;
    endfunction

endpackage

// File: rtl/vram_wbuf.sv
// vram_wbuf: one-entry posted-write buffer; a load in the same cycle as a drain keeps it full with the new entry.
module vram_wbuf #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk_pixel,
    input  logic              reset,
    input  logic              load_i,
    input  logic              drain_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        valid_d = load_i | (valid_q & ~drain_i);
        addr_d  = load_i ? addr_i : addr_q;
        data_d  = load_i ? data_i : data_q;
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign data_o  = data_q;

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port video RAM arbiter; video fetches always win, CPU reads fill free slots,
// CPU writes are posted through a one-entry buffer that drains ahead of any CPU read.
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_pixel,
    input  logic              reset,
    input  logic              vid_rd,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            state_q, state_d;
    owner_e            owner;
    logic              cpu_ack_q;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              wb_valid, wb_drain, wr_accept, rd_issue, is_idle;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    vram_wbuf #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_wbuf (
        .clk_pixel(clk_pixel),
        .reset    (reset),
        .load_i   (wr_accept),
        .drain_i  (wb_drain),
        .addr_i   (cpu_addr),
        .data_i   (cpu_wdata),
        .valid_o  (wb_valid),
        .addr_o   (wb_addr),
        .data_o   (wb_data)
    );

    always_comb begin
        is_idle     = state_q == ST_IDLE;
        wb_drain    = wb_valid && !vid_rd;
        wr_accept   = is_idle && cpu_req && cpu_we && (!wb_valid || wb_drain);
        rd_issue    = is_idle && cpu_req && !cpu_we && !wb_valid && !vid_rd;
        owner       = slot_owner(vid_rd, wb_valid, rd_issue);
        state_d     = is_idle ? (wr_accept ? ST_ACK : rd_issue ? ST_RD_WAIT : ST_IDLE)
                    : (state_q == ST_RD_WAIT) ? ST_ACK : ST_IDLE;
        cpu_rdata_d = (state_q == ST_RD_WAIT) ? mem_rdata : cpu_rdata_q;
    end

    // RAM strobes are forced low for the whole reset assertion, not just after the next edge.
    always_comb begin
        mem_en    = !reset && owner != OWN_NONE;
        mem_we    = !reset && owner == OWN_WB;
        mem_addr  = owner == OWN_VID ? vid_addr : owner == OWN_WB ? wb_addr : cpu_addr;
        mem_wdata = wb_data;
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cpu_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cpu_ack_q   <= state_d == ST_ACK;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

    assign cpu_ack   = cpu_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign vid_data  = mem_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: randomized CPU/video traffic against a shadow-memory model of RAM contents and write order.
module tb_vram_arbiter;

    logic        clk_pixel = 1'b0;
    logic        reset = 1'b1;
    logic        vid_rd = 1'b0;
    logic [15:0] vid_addr = '0;
    logic [7:0]  vid_data;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;

    vram_arbiter dut (
        .clk_pixel(clk_pixel),
        .reset    (reset),
        .vid_rd   (vid_rd),
        .vid_addr (vid_addr),
        .vid_data (vid_data),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_ack  (cpu_ack),
        .cpu_rdata(cpu_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk_pixel = ~clk_pixel;

    logic [7:0]  ram    [0:65535];
    logic [7:0]  shadow [0:65535];
    logic [23:0] exp_q[$];
    int          checks = 0, failures = 0;
    int          exp_wr = 0, ram_writes = 0, cyc = 0, lat = 0, saved = 0;
    bit          vid_mode = 1'b0;
    logic        vp = 1'b0;
    logic [7:0]  vexp = '0, old = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk_pixel)
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else mem_rdata <= ram[mem_addr];
        end

    always @(negedge clk_pixel) begin
        if (vp && !reset) check("vid_data", vid_data, vexp);
        vp = 1'b0;
        if (vid_rd && !reset) begin
            check("vid_en", mem_en, 1);
            check("vid_we", mem_we, 0);
            check("vid_addr", mem_addr, vid_addr);
            vexp = ram[vid_addr];
            vp = 1'b1;
        end
        if (!reset && mem_en && mem_we) begin
            ram_writes++;
            if (exp_q.size() != 0) begin
                logic [23:0] e;
                e = exp_q.pop_front();
                check("wr_addr", mem_addr, e[23:8]);
                check("wr_data", mem_wdata, e[7:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk_pixel);
        #1;
        cyc++;
        if (vid_mode) begin
            vid_rd   = (cyc % 8) == 0;
            vid_addr = 16'($urandom);
        end
    endtask

    task automatic idle(input int n);
        cpu_req = 1'b0;
        repeat (n) tick();
    endtask

    task automatic cpu_txn(input bit we, input logic [15:0] a, input logic [7:0] d, output int l);
        logic [7:0] er;
        cpu_req = 1'b1;
        cpu_we = we;
        cpu_addr = a;
        cpu_wdata = d;
        er = shadow[a];
        if (we) begin
            shadow[a] = d;
            exp_q.push_back({a, d});
            exp_wr++;
        end
        l = 0;
        do begin
            tick();
            l++;
        end while (!cpu_ack && l < 20);
        check("ack_seen", cpu_ack, 1);
        if (!we) check("rdata", cpu_rdata, er);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ram[i] = 8'($urandom);
            shadow[i] = ram[i];
        end
        ram[16'h1234] = 8'hA5;
        shadow[16'h1234] = 8'hA5;
        vid_rd = 1'b1;
        #1;
        check("rst_en", mem_en, 0);
        check("rst_we", mem_we, 0);
        check("rst_ack", cpu_ack, 0);
        check("rst_rdata", cpu_rdata, 0);
        vid_rd = 1'b0;
        repeat (2) @(posedge clk_pixel);
        #1;
        reset = 1'b0;
        idle(2);

        vid_rd = 1'b1;
        vid_addr = 16'h1234;
        #1;
        check("v_en", mem_en, 1);
        check("v_addr", mem_addr, 16'h1234);
        tick();
        vid_rd = 1'b0;
        #1;
        check("v_data", vid_data, 8'hA5);
        idle(2);

        cpu_txn(1'b1, 16'h0040, 8'h5A, lat);
        check("wr_lat", lat, 1);
        cpu_txn(1'b0, 16'h0040, 8'h00, lat);
        check("raw_lat", lat, 3);
        check("raw_data", cpu_rdata, 8'h5A);
        idle(2);
        cpu_txn(1'b0, 16'h0040, 8'h00, lat);
        check("rd_lat", lat, 2);
        idle(1);
        tick();

        vid_rd = 1'b1;
        vid_addr = 16'h2000;
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 16'h0100;
        #1;
        check("col_vaddr", mem_addr, 16'h2000);
        tick();
        vid_rd = 1'b0;
        #1;
        check("col_issue_en", mem_en, 1);
        check("col_issue_addr", mem_addr, 16'h0100);
        lat = 1;
        while (!cpu_ack && lat < 20) begin
            tick();
            lat++;
        end
        check("col_lat", lat, 3);
        check("col_data", cpu_rdata, shadow[16'h0100]);
        idle(2);

        vid_mode = 1'b1;
        for (int i = 0; i < 12; i++) cpu_txn(1'b1, 16'h0200 + 16'(i), 8'($urandom), lat);
        for (int i = 0; i < 150; i++) begin
            cpu_txn(1'($urandom_range(0, 1)), {12'h004, 4'($urandom_range(0, 15))}, 8'($urandom), lat);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(10);
        vid_mode = 1'b0;
        vid_rd = 1'b0;
        idle(2);
        check("wr_pending", exp_q.size(), 0);
        check("wr_count", ram_writes, exp_wr);
        for (int i = 0; i < 12; i++) check("ram_b2b", ram[16'h0200 + 16'(i)], shadow[16'h0200 + 16'(i)]);
        for (int i = 0; i < 16; i++) check("ram_rnd", ram[16'h0040 + 16'(i)], shadow[16'h0040 + 16'(i)]);

        cpu_txn(1'b0, 16'h1234, 8'h00, lat);
        idle(2);
        old = ram[16'h0077];
        saved = ram_writes;
        cpu_req = 1'b1;
        cpu_we = 1'b1;
        cpu_addr = 16'h0077;
        cpu_wdata = ~old;
        tick();
        cpu_req = 1'b0;
        vid_rd = 1'b1;
        vid_addr = 16'h0300;
        #1;
        check("defer_we", mem_we, 0);
        check("defer_addr", mem_addr, 16'h0300);
        reset = 1'b1;
        #1;
        check("ar_ack", cpu_ack, 0);
        check("ar_en", mem_en, 0);
        check("ar_we", mem_we, 0);
        vid_rd = 1'b0;
        @(posedge clk_pixel);
        #1;
        reset = 1'b0;
        idle(4);
        check("ar_ram", ram[16'h0077], old);
        check("ar_writes", ram_writes, saved);
        check("ar_rdata", cpu_rdata, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
